// File: rtl/byte_word_loader.sv
// Packs a valid/ready byte stream little-endian into 32-bit words and pulses word_load for one clock.
// Optional odd-parity checking of incoming bytes is enabled with `define BYTE_WORD_LOADER_PARITY_EN.
module byte_word_loader #(
    parameter int          TIMEOUT    = 15,
    parameter int          TO_W       = 4,
    parameter logic [31:0] RESET_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
`ifdef BYTE_WORD_LOADER_PARITY_EN
    input  logic        in_parity,
    output logic        parity_err,
`endif
    output logic [31:0] word_out,
    output logic        word_load,
    output logic [1:0]  byte_cnt,
    output logic        drop,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, FILL, LOAD} state_t;

    state_t          state, state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic [23:0]     shift_buf;   // bytes 0..2; byte 3 goes straight into word_out
    logic            word_bad;
    logic            accept;
    logic            last_byte;
    logic            expire;
    logic            byte_bad;
    logic            bad_now;

    assign in_ready  = rst_n && (state != LOAD);
    assign accept    = in_valid && in_ready;
    assign last_byte = (byte_cnt == 2'd3);

`ifdef BYTE_WORD_LOADER_PARITY_EN
    assign byte_bad   = ~^{in_parity, in_data};
    assign parity_err = (state == LOAD) && word_bad;
`else
    assign byte_bad   = 1'b0;
`endif
    assign bad_now = word_bad || byte_bad;

    // A byte accepted on the expiry edge takes priority, so expiry requires no accept.
    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign expire = 1'b0;
        end else begin : g_timeout
            assign expire = (state == FILL) && !accept && (to_cnt == TO_W'(TIMEOUT - 1));
        end
    endgenerate

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = FILL;
            FILL: begin
                if (accept && last_byte) state_nxt = LOAD;
                else if (expire)         state_nxt = IDLE;
            end
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all registered state to avoid ordering races.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt  <= 2'd0;
            to_cnt    <= '0;
            shift_buf <= '0;
            word_out  <= RESET_WORD;
            drop      <= 1'b0;
            word_bad  <= 1'b0;
        end else begin
            drop <= 1'b0;
            if (state == LOAD) word_bad <= 1'b0;
            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                to_cnt   <= '0;
                if (last_byte) begin
                    shift_buf <= '0;
                    word_bad  <= bad_now;
                    if (!bad_now) word_out <= {in_data, shift_buf};
                end else begin
                    shift_buf[{byte_cnt, 3'b000} +: 8] <= in_data;
                    word_bad                           <= bad_now;
                end
            end else if (expire) begin
                byte_cnt  <= 2'd0;
                to_cnt    <= '0;
                shift_buf <= '0;
                word_bad  <= 1'b0;
                drop      <= 1'b1;
            end else if (state == FILL) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign word_load = (state == LOAD) && !word_bad;
    assign busy      = (byte_cnt != 2'd0) || (state == LOAD);

endmodule
